mb_buffer_scheduler: RTL
========================

# mb_buffer_scheduler

Central sequencer for the multibuffered BRAM-to-AXIS output adapter. It tracks up to eight ping-pong buffers through the states started, filled and drained, using three event pulses:
- accelerator start;
- accelerator done;
- output streamer finished.

From these it drives the buffer-select indices and the allow/ready flags consumed by the BRAM demuxes and the stream interface. It replaces ad-hoc pointer logic with occupancy counters, so simultaneous events and depth-1 operation are handled uniformly.

## Interface
- C_MB_DEPTH, 2, number of buffers, legal range 1..8.
- C_SEL_BITS, 3, width of the select outputs; must satisfy 2^C_SEL_BITS >= C_MB_DEPTH.

Ports:
- ACC_CLK  in  1  single clock; all logic on its rising edge.
- ARESET  in  1  reset, synchronous and active-high.
- CTRL_ACC_START  in  1  one-cycle pulse: accelerator begins a buffer.
- CTRL_ACC_DONE  in  1  one-cycle pulse: accelerator finished writing the current buffer.
- OUT_FINISHED  in  1  one-cycle pulse from the stream interface: current output buffer fully sent (TLAST accepted).
- CTRL_CANSTART  out  1  a free buffer exists; a start is accepted.
- CTRL_READY  out  1  the accelerator may write the buffer at ACC_SEL.
- OUT_ALLOW  out  1  at least one filled buffer awaits streaming.
- START_SEL  out  C_SEL_BITS  index the next start will claim.
- ACC_SEL  out  C_SEL_BITS  buffer the accelerator currently writes; drives the accelerator-port demuxes.
- OUT_SEL  out  C_SEL_BITS  buffer the streamer currently reads; drives the output mux.
- OCCUPANCY  out  4  number of buffers started or filled but not yet drained, 0..C_MB_DEPTH.
- ERR_FLAGS  out  3  sticky protocol-error bits:
  - bit 0: start while full;
  - bit 1: done with nothing in flight;
  - bit 2: finish with nothing filled.

## Operation
Internal state:
- pointers start_ptr, acc_ptr, out_ptr, each 0..C_MB_DEPTH-1;
- counters inflight (started, not done) and filled (done, not drained), each 4 bits;
- invariant: inflight + filled <= C_MB_DEPTH.

Event acceptance is evaluated against the registered state at the start of the cycle:
- **START** accepted iff CTRL_CANSTART=1 → start_ptr advances, inflight+1.
- **DONE** accepted iff inflight>0 → acc_ptr advances, inflight-1, filled+1.
- **FINISH** accepted iff filled>0 → out_ptr advances, filled-1.

Pointer and counter rules:
- Pointer advance: ptr==C_MB_DEPTH-1 → 0, else ptr+1.
- With C_MB_DEPTH=1, all pointers stay 0.
- Any subset of the three events in one cycle is applied together. The counter update is the net sum, e.g. DONE+FINISH leaves filled unchanged and decrements inflight.
- A FINISH in the same cycle does not make room for a START rejected while full; that START is dropped.
- Rejected events change no state.

Registered outputs, derived from next-state values:
- CTRL_CANSTART = (inflight+filled < C_MB_DEPTH).
- CTRL_READY = (filled < C_MB_DEPTH).
- OUT_ALLOW = (filled > 0).
- OCCUPANCY = inflight+filled.
- START_SEL, ACC_SEL and OUT_SEL equal their pointers.

Reset:
- All pointers, counters, OCCUPANCY and ERR_FLAGS go to 0.
- CTRL_CANSTART=1, CTRL_READY=1, OUT_ALLOW=0.
- Reset mid-operation discards all buffer state; a pulse coincident with ARESET is ignored.

## Timing
- Every output is a flop; latency from any event pulse to the updated outputs is exactly 1 cycle.
- No combinational path from inputs to outputs.
- An event is counted once per high cycle. Holding a pulse high for N cycles counts as N events, each separately subject to acceptance.
- Back-to-back pulses are legal every cycle. Sustained throughput: one start, one done and one finish per cycle.
- Full boundary: on the cycle after the start that makes OCCUPANCY==C_MB_DEPTH, CTRL_CANSTART=0. It returns to 1 on the cycle after the next accepted FINISH.
- Empty boundary: OUT_ALLOW falls on the cycle after the FINISH that takes filled to 0, unless a DONE arrives in the same cycle.

## Configuration
- Macro MB_SCHED_ERR_EN.
- Defined: ERR_FLAGS bits set on the cycle after the corresponding rejected event and hold until ARESET.
- Undefined: the error logic is not compiled and ERR_FLAGS is constant 0. Rejection behaviour is identical either way.

## Test plan
- **Reset values:** assert ARESET for 2 cycles with random pulses applied → CTRL_CANSTART=1, CTRL_READY=1, OUT_ALLOW=0, OCCUPANCY=0, all selects 0, ERR_FLAGS=0.
- **Fill to full (C_MB_DEPTH=4):** 4 START pulses, then 4 DONE pulses → START_SEL sequence 1,2,3,0; CTRL_CANSTART=0 after the 4th start; OUT_ALLOW=1 after the first done; OCCUPANCY=4; then a 5th START → ignored, ERR_FLAGS[0]=1 with MB_SCHED_ERR_EN defined.
- **Drain and wrap (C_MB_DEPTH=4):** from full, 4 FINISH pulses → OUT_SEL 1,2,3,0; OUT_ALLOW=0 after the 4th; CTRL_CANSTART=1 after the 1st.
- **Simultaneous events (C_MB_DEPTH=3):** with inflight=1 and filled=1, pulse START+DONE+FINISH in one cycle → next cycle inflight=1, filled=1, OCCUPANCY=2; all three pointers advance by 1.
- **Depth 1:** START, DONE, FINISH in sequence → all selects stay 0; CTRL_CANSTART 1→0→0→1; OUT_ALLOW 0→0→1→0.
- **Illegal event and reset mid-operation:** DONE with inflight=0 → no state change, ERR_FLAGS[1]=1 with the macro defined and 0 without it; then ARESET at OCCUPANCY=2 → all outputs return to reset values in the next cycle.

Source files
------------

// File: rtl/mb_buffer_scheduler.sv
// ---------------------------------------------------------------------------
// mb_buffer_scheduler
//
// Central sequencer for the multibuffered BRAM-to-AXIS output adapter.
// Buffers move through three phases: started (accelerator writing), filled
// (written, waiting for the streamer) and drained (free again). Three ring
// pointers pick the buffer for each phase. Two occupancy counters replace
// pointer comparisons, so simultaneous events and depth-1 operation behave
// the same way as every other case.
//
// Parameters:
//   C_MB_DEPTH  number of buffers, 1..8
//   C_SEL_BITS  width of the select outputs, 2**C_SEL_BITS >= C_MB_DEPTH
//
// Ports:
//   ACC_CLK         in   clock, all logic on the rising edge
//   ARESET          in   synchronous active-high reset
//   CTRL_ACC_START  in   pulse: accelerator begins a buffer
//   CTRL_ACC_DONE   in   pulse: accelerator finished the current buffer
//   OUT_FINISHED    in   pulse: streamer finished the current buffer
//   CTRL_CANSTART   out  a free buffer exists, so a start is accepted
//   CTRL_READY      out  accelerator may write the buffer at ACC_SEL
//   OUT_ALLOW       out  at least one filled buffer awaits streaming
//   START_SEL       out  index the next start will claim
//   ACC_SEL         out  buffer the accelerator is writing
//   OUT_SEL         out  buffer the streamer is reading
//   OCCUPANCY       out  buffers started or filled but not yet drained
//   ERR_FLAGS       out  sticky errors: [0] start while full,
//                        [1] done with nothing in flight,
//                        [2] finish with nothing filled
//
// Event handshake: each input pulse is one request, counted once per high
// cycle. It is accepted only when the registered state at the start of that
// cycle permits it. There is no back-pressure; a rejected pulse is dropped
// and changes no state.
//
// Build option: define MB_SCHED_ERR_EN to compile the sticky error flags.
// Without it ERR_FLAGS is tied to 0. Rejection behaviour is the same
// either way.
// ---------------------------------------------------------------------------
module mb_buffer_scheduler #(
    parameter int C_MB_DEPTH = 2,
    parameter int C_SEL_BITS = 3
) (
    input  logic                  ACC_CLK,
    input  logic                  ARESET,
    input  logic                  CTRL_ACC_START,
    input  logic                  CTRL_ACC_DONE,
    input  logic                  OUT_FINISHED,
    output logic                  CTRL_CANSTART,
    output logic                  CTRL_READY,
    output logic                  OUT_ALLOW,
    output logic [C_SEL_BITS-1:0] START_SEL,
    output logic [C_SEL_BITS-1:0] ACC_SEL,
    output logic [C_SEL_BITS-1:0] OUT_SEL,
    output logic [3:0]            OCCUPANCY,
    output logic [2:0]            ERR_FLAGS
);

    localparam logic [3:0]            DEPTH_C    = 4'(C_MB_DEPTH);
    localparam logic [C_SEL_BITS-1:0] LAST_PTR_C = C_SEL_BITS'(C_MB_DEPTH - 1);

    // Ring advance. With depth 1 the last index is 0, so pointers stay 0.
    function automatic logic [C_SEL_BITS-1:0] next_ptr(input logic [C_SEL_BITS-1:0] p);
        if (p == LAST_PTR_C) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // State registers
    logic [C_SEL_BITS-1:0] start_ptr_q, start_ptr_d;
    logic [C_SEL_BITS-1:0] acc_ptr_q,   acc_ptr_d;
    logic [C_SEL_BITS-1:0] out_ptr_q,   out_ptr_d;
    logic [3:0]            inflight_q,  inflight_d;
    logic [3:0]            filled_q,    filled_d;

    // Registered outputs
    logic                  canstart_q,  canstart_d;
    logic                  ready_q,     ready_d;
    logic                  allow_q,     allow_d;
    logic [3:0]            occ_q,       occ_d;

    // Acceptance uses the registered state only. In particular, a FINISH in
    // the same cycle does not rescue a START that arrives while full.
    logic start_acc, done_acc, fin_acc;

    always_comb begin
        start_acc = CTRL_ACC_START && canstart_q;
        done_acc  = CTRL_ACC_DONE  && (inflight_q != 4'd0);
        fin_acc   = OUT_FINISHED   && (filled_q   != 4'd0);
    end

    // Next-state: all accepted events apply together as a net sum.
    always_comb begin
        start_ptr_d = start_acc ? next_ptr(start_ptr_q) : start_ptr_q;
        acc_ptr_d   = done_acc  ? next_ptr(acc_ptr_q)   : acc_ptr_q;
        out_ptr_d   = fin_acc   ? next_ptr(out_ptr_q)   : out_ptr_q;

        inflight_d  = inflight_q + {3'd0, start_acc} - {3'd0, done_acc};
        filled_d    = filled_q   + {3'd0, done_acc}  - {3'd0, fin_acc};

        occ_d       = inflight_d + filled_d;
        canstart_d  = (occ_d < DEPTH_C);
        ready_d     = (filled_d < DEPTH_C);
        allow_d     = (filled_d != 4'd0);
    end

    always_ff @(posedge ACC_CLK) begin
        if (ARESET) begin
            start_ptr_q <= '0;
            acc_ptr_q   <= '0;
            out_ptr_q   <= '0;
            inflight_q  <= '0;
            filled_q    <= '0;
            occ_q       <= '0;
            canstart_q  <= 1'b1;
            ready_q     <= 1'b1;
            allow_q     <= 1'b0;
        end else begin
            start_ptr_q <= start_ptr_d;
            acc_ptr_q   <= acc_ptr_d;
            out_ptr_q   <= out_ptr_d;
            inflight_q  <= inflight_d;
            filled_q    <= filled_d;
            occ_q       <= occ_d;
            canstart_q  <= canstart_d;
            ready_q     <= ready_d;
            allow_q     <= allow_d;
        end
    end

`ifdef MB_SCHED_ERR_EN
    // Sticky protocol-error flags, cleared only by reset.
    logic [2:0] err_q, err_d;

    always_comb begin
        err_d = err_q | {OUT_FINISHED   && !fin_acc,
                         CTRL_ACC_DONE  && !done_acc,
                         CTRL_ACC_START && !start_acc};
    end

    always_ff @(posedge ACC_CLK) begin
        if (ARESET) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign ERR_FLAGS = err_q;
`else
    assign ERR_FLAGS = 3'b000;
`endif

    assign CTRL_CANSTART = canstart_q;
    assign CTRL_READY    = ready_q;
    assign OUT_ALLOW     = allow_q;
    assign START_SEL     = start_ptr_q;
    assign ACC_SEL       = acc_ptr_q;
    assign OUT_SEL       = out_ptr_q;
    assign OCCUPANCY     = occ_q;

endmodule
